// File: rtl/updown_counter_n.sv
// updown_counter_n: synchronous, parametrised up/down counter with a modulus.
// It supports clear, clamped load, wrap or saturate modes, and status flags:
// tc (combinational), plus registered wrap, match and sticky sat.
module updown_counter_n #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 2**WIDTH-1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap,
  output logic             match,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  localparam logic             SAT_MODE = (SATURATE != 0);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             sat_r;
  logic             match_r;

  logic [WIDTH-1:0] q_next_s;
  logic             wrap_next_s;
  logic             sat_next_s;
  logic             at_top_s;
  logic             at_bottom_s;

  // Out-of-range values (above MAX) behave like the top boundary when counting up.
  assign at_top_s    = (q_r >= MAX_V);
  assign at_bottom_s = (q_r == ZERO_V);

  // Next-state selection with priority clr > load > en.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    sat_next_s  = sat_r;
    if (clr) begin
      q_next_s   = ZERO_V;
      sat_next_s = 1'b0;
    end else if (load) begin
      q_next_s   = (din > MAX_V) ? MAX_V : din;
      sat_next_s = 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_top_s) begin
          if (SAT_MODE) begin
            sat_next_s = 1'b1;
          end else begin
            q_next_s    = ZERO_V;
            wrap_next_s = 1'b1;
          end
        end else begin
          q_next_s = q_r + ONE_V;
        end
      end else begin
        if (at_bottom_s) begin
          if (SAT_MODE) begin
            sat_next_s = 1'b1;
          end else begin
            q_next_s    = MAX_V;
            wrap_next_s = 1'b1;
          end
        end else begin
          q_next_s = q_r - ONE_V;
        end
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // State and flag registers; match tracks the value being written into q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= ZERO_V;
      wrap_r  <= 1'b0;
      sat_r   <= 1'b0;
      match_r <= 1'b0;
    end else begin
      q_r     <= q_next_s;
      wrap_r  <= wrap_next_s;
      sat_r   <= sat_next_s;
      match_r <= (q_next_s == cmp);
    end
  end

  // Terminal count looks at the live direction and enable, not the mode.
  always_comb begin
    tc = 1'b0;
    if (en) begin
      tc = up ? (q_r == MAX_V) : (q_r == ZERO_V);
    end else begin
      tc = 1'b0;
    end
  end

  assign q     = q_r;
  assign qb    = ~q_r;
  assign wrap  = wrap_r;
  assign match = match_r;
  assign sat   = sat_r;

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n, WIDTH=4 and MAX=9.
// It runs a wrapping and a saturating instance from the same stimulus.
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, up;
  logic [3:0] din, cmp;
  logic [3:0] q0, qb0, q1, qb1;
  logic       tc0, wrap0, match0, sat0;
  logic       tc1, wrap1, match1, sat1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(4), .MAX(9), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .cmp(cmp), .q(q0), .qb(qb0), .tc(tc0), .wrap(wrap0), .match(match0), .sat(sat0)
  );

  updown_counter_n #(.WIDTH(4), .MAX(9), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .cmp(cmp), .q(q1), .qb(qb1), .tc(tc1), .wrap(wrap1), .match(match1), .sat(sat1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0;
    din = 4'd0; cmp = 4'd0;
    #2;
    chk("rst_q", q0, 4'd0);
    chk("rst_qb", qb0, 4'hF);
    chk("rst_wrap", wrap0, 1'b0);
    chk("rst_sat", sat0, 1'b0);
    chk("rst_match", match0, 1'b0);

    // Count up through the wrap.
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      e = 4'(i % 10);
      chk("up_q", q0, e);
      chk("up_wrap", wrap0, (i == 10));
      chk("up_tc", tc0, (e == 4'd9));
      chk("up_match", match0, (e == 4'd0));
      chk("up_sat0", sat0, 1'b0);
    end
    chk("up_qb", qb0, 4'hD);

    // Load with enable set, then count down through the wrap.
    load = 1'b1; din = 4'd5; up = 1'b0;
    step();
    chk("ld_en_q", q0, 4'd5);
    chk("ld_en_wrap", wrap0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k <= 5) ? 4'(5 - k) : 4'(15 - k);
      chk("dn_q", q0, e);
      chk("dn_wrap", wrap0, (k == 6));
      chk("dn_tc", tc0, (e == 4'd0));
    end

    // Saturating instance: climb from 8 and stick at 9.
    load = 1'b1; din = 4'd8; en = 1'b0;
    step();
    chk("sat_ld8", q1, 4'd8);
    chk("sat_ld8_sat", sat1, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    chk("sat_q_a", q1, 4'd9);
    chk("sat_flag_a", sat1, 1'b0);
    chk("sat_tc", tc1, 1'b1);
    step();
    chk("sat_q_b", q1, 4'd9);
    chk("sat_flag_b", sat1, 1'b1);
    chk("sat_nowrap", wrap1, 1'b0);
    step();
    chk("sat_q_c", q1, 4'd9);
    chk("sat_flag_c", sat1, 1'b1);
    chk("wrapmode_q", q0, 4'd1);
    load = 1'b1; din = 4'd3; en = 1'b0;
    step();
    chk("sat_ld3_q", q1, 4'd3);
    chk("sat_ld3_sat", sat1, 1'b0);

    // Load above MAX clamps.
    din = 4'd14;
    step();
    chk("clamp_q0", q0, 4'd9);
    chk("clamp_q1", q1, 4'd9);

    // Clear beats load and enable.
    clr = 1'b1; load = 1'b1; en = 1'b1; din = 4'd7;
    step();
    chk("clr_prio_q", q0, 4'd0);
    chk("clr_prio_wrap", wrap0, 1'b0);
    chk("clr_match0", match0, 1'b1);
    clr = 1'b0; load = 1'b0;

    // Compare match while counting up from 0.
    cmp = 4'd4; up = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("m_q", q0, 4'(i));
      chk("m_match", match0, (i == 4));
    end
    en = 1'b0;
    step();
    chk("m_hold_q", q0, 4'd4);
    chk("m_hold_match", match0, 1'b1);
    chk("m_hold_wrap", wrap0, 1'b0);
    en = 1'b1;
    step();
    chk("m_q5", q0, 4'd5);
    chk("m_match5", match0, 1'b0);
    step();
    cmp = 4'd7;
    step();
    chk("pre_rst_q", q0, 4'd7);
    chk("pre_rst_match", match0, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b1;
    #1;
    chk("arst_q", q0, 4'd0);
    chk("arst_qb", qb0, 4'hF);
    chk("arst_wrap", wrap0, 1'b0);
    chk("arst_sat", sat0, 1'b0);
    chk("arst_match", match0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("resume_q1", q0, 4'd1);
    step();
    chk("resume_q2", q0, 4'd2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
